// File: rtl/core_mem_arb.sv
// Shared simulation memory: NUM_PORTS req/gnt/rvalid masters, round-robin
// arbitration, fixed response latency and out-of-range error response.
module core_mem_arb #(
  parameter int          NUM_PORTS  = 2,
  parameter int          DATA_WIDTH = 64,
  parameter int          MEM_AW     = 24,
  parameter logic [63:0] BASE_ADDR  = 64'h8000_0000,
  parameter int          LATENCY    = 1
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NUM_PORTS-1:0]                req_i,
  input  logic [NUM_PORTS*64-1:0]             addr_i,
  input  logic [NUM_PORTS-1:0]                we_i,
  input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0] be_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]     wdata_i,
  output logic [NUM_PORTS-1:0]                gnt_o,
  output logic [NUM_PORTS-1:0]                rvalid_o,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]     rdata_o,
  output logic [NUM_PORTS-1:0]                err_o
);

  localparam int          BW        = DATA_WIDTH / 8;
  localparam int          BOFF      = (BW > 1) ? $clog2(BW) : 0;
  localparam int          PW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int          DEPTH     = 2 ** MEM_AW;
  localparam logic [63:0] MEM_BYTES = 64'd1 << (MEM_AW + BOFF);

  // ---------------------------------------------------------------
  // Round-robin arbiter: pointer register, next-pointer, grant decode
  // ---------------------------------------------------------------
  logic [PW-1:0] rr_ptr_q;
  logic [PW-1:0] rr_ptr_d;
  logic [PW-1:0] gnt_idx;
  logic          gnt_any;
  int            scan_idx;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rr_ptr_q <= '0;
    else         rr_ptr_q <= rr_ptr_d;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_any) begin
      if (gnt_idx == PW'(NUM_PORTS - 1)) rr_ptr_d = '0;
      else                               rr_ptr_d = gnt_idx + PW'(1);
    end
  end

  // Scan ports starting at the pointer; the first requester wins.
  always_comb begin
    gnt_o    = '0;
    gnt_idx  = '0;
    gnt_any  = 1'b0;
    scan_idx = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      scan_idx = int'(rr_ptr_q) + i;
      if (scan_idx >= NUM_PORTS) scan_idx = scan_idx - NUM_PORTS;
      if (!gnt_any && req_i[scan_idx]) begin
        gnt_o[scan_idx] = 1'b1;
        gnt_idx         = PW'(scan_idx);
        gnt_any         = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------
  // Granted-port mux and address decode
  // ---------------------------------------------------------------
  logic [63:0]           sel_addr;
  logic [63:0]           sel_off;
  logic                  sel_we;
  logic [BW-1:0]         sel_be;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  in_range;
  logic [MEM_AW-1:0]     word_idx;

  always_comb begin
    sel_addr  = addr_i[int'(gnt_idx)*64 +: 64];
    sel_we    = we_i[gnt_idx];
    sel_be    = be_i[int'(gnt_idx)*BW +: BW];
    sel_wdata = wdata_i[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
    sel_off   = sel_addr - BASE_ADDR;
    // Below-base addresses would wrap to a huge offset; reject them explicitly.
    in_range  = (sel_addr >= BASE_ADDR) && (sel_off < MEM_BYTES);
    word_idx  = sel_off[BOFF +: MEM_AW];
  end

  // ---------------------------------------------------------------
  // Backing RAM (contents deliberately not reset)
  // ---------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (gnt_any && in_range && sel_we) begin
      for (int b = 0; b < BW; b++) begin
        if (sel_be[b]) mem[word_idx][b*8 +: 8] <= sel_wdata[b*8 +: 8];
      end
    end
  end

  logic                  s0_err;
  logic [DATA_WIDTH-1:0] s0_data;

  always_comb begin
    s0_err  = !in_range;
    s0_data = '0;
    if (gnt_any && in_range && !sel_we) s0_data = mem[word_idx];
  end

  // ---------------------------------------------------------------
  // Response pipeline: LATENCY stages of {valid, port, err, data}
  // ---------------------------------------------------------------
  logic                  pipe_v [LATENCY];
  logic [PW-1:0]         pipe_p [LATENCY];
  logic                  pipe_e [LATENCY];
  logic [DATA_WIDTH-1:0] pipe_d [LATENCY];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < LATENCY; s++) begin
        pipe_v[s] <= 1'b0;
        pipe_p[s] <= '0;
        pipe_e[s] <= 1'b0;
        pipe_d[s] <= '0;
      end
    end else begin
      pipe_v[0] <= gnt_any;
      pipe_p[0] <= gnt_idx;
      pipe_e[0] <= s0_err;
      pipe_d[0] <= s0_data;
      for (int s = 1; s < LATENCY; s++) begin
        pipe_v[s] <= pipe_v[s-1];
        pipe_p[s] <= pipe_p[s-1];
        pipe_e[s] <= pipe_e[s-1];
        pipe_d[s] <= pipe_d[s-1];
      end
    end
  end

  always_comb begin
    rvalid_o = '0;
    err_o    = '0;
    rdata_o  = '0;
    if (pipe_v[LATENCY-1]) begin
      rvalid_o[pipe_p[LATENCY-1]]                              = 1'b1;
      err_o[pipe_p[LATENCY-1]]                                 = pipe_e[LATENCY-1];
      rdata_o[int'(pipe_p[LATENCY-1])*DATA_WIDTH +: DATA_WIDTH] = pipe_d[LATENCY-1];
    end
  end

endmodule

// File: tb/tb_core_mem_arb.sv
// Directed bench for core_mem_arb: a LATENCY=1 and a LATENCY=3 instance,
// table-driven single-access vectors plus arbitration/latency/reset sequences.
module tb_core_mem_arb;

  localparam int          AW   = 10;
  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam logic [63:0] TOP  = BASE + (64'd1 << (AW + 3));
  localparam logic [63:0] LAST = TOP - 64'd8;
  localparam logic [63:0] DEAD = 64'hDEAD_BEEF_0123_4567;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] HALF = 64'h0000_0000_FFFF_FFFF;
  localparam logic [63:0] PATT = 64'h1111_2222_3333_4444;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_na, rst_nb;
  logic [1:0]   reqa, wea, gnta, rva, erra;
  logic [127:0] addra, wdataa, rdataa;
  logic [15:0]  bea;
  logic [1:0]   reqb, web, gntb, rvb, errb;
  logic [127:0] addrb, wdatab, rdatab;
  logic [15:0]  beb;

  core_mem_arb #(.NUM_PORTS(2), .DATA_WIDTH(64), .MEM_AW(AW), .BASE_ADDR(BASE), .LATENCY(1)) dut_a (
    .clk_i(clk), .rst_ni(rst_na), .req_i(reqa), .addr_i(addra), .we_i(wea), .be_i(bea),
    .wdata_i(wdataa), .gnt_o(gnta), .rvalid_o(rva), .rdata_o(rdataa), .err_o(erra));

  core_mem_arb #(.NUM_PORTS(2), .DATA_WIDTH(64), .MEM_AW(AW), .BASE_ADDR(BASE), .LATENCY(3)) dut_b (
    .clk_i(clk), .rst_ni(rst_nb), .req_i(reqb), .addr_i(addrb), .we_i(web), .be_i(beb),
    .wdata_i(wdatab), .gnt_o(gntb), .rvalid_o(rvb), .rdata_o(rdatab), .err_o(errb));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic [1:0] req, input logic we, input logic [63:0] a0,
                         input logic [63:0] a1, input logic [7:0] be, input logic [63:0] wd);
    reqa = req; wea = {we, we}; addra = {a1, a0}; bea = {be, be}; wdataa = {wd, wd};
  endtask

  task automatic drive_b(input logic [1:0] req, input logic we, input logic [63:0] a0,
                         input logic [63:0] a1, input logic [7:0] be, input logic [63:0] wd);
    reqb = req; web = {we, we}; addrb = {a1, a0}; beb = {be, be}; wdatab = {wd, wd};
  endtask

  function automatic logic [127:0] flat(input logic [1:0] rv, input logic [63:0] rd);
    case (rv)
      2'b01:   return {64'd0, rd};
      2'b10:   return {rd, 64'd0};
      default: return 128'd0;
    endcase
  endfunction

  typedef struct {
    logic [1:0]  req;
    logic        we;
    logic [63:0] addr;
    logic [7:0]  be;
    logic [63:0] wd;
    logic [1:0]  gnt;
    logic [1:0]  rv;
    logic [63:0] rd;
    logic [1:0]  err;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] req, input logic we, input logic [63:0] addr,
                              input logic [7:0] be, input logic [63:0] wd, input logic [1:0] gnt,
                              input logic [1:0] rv, input logic [63:0] rd, input logic [1:0] err);
    vec_t v;
    v.req = req; v.we = we; v.addr = addr; v.be = be; v.wd = wd;
    v.gnt = gnt; v.rv = rv; v.rd = rd; v.err = err;
    return v;
  endfunction

  vec_t tbl [16];
  logic [63:0] bdat [3];

  initial begin
    tbl[0]  = mk(2'b00, 1'b0, BASE,               8'hFF, 64'd0, 2'b00, 2'b00, 64'd0, 2'b00);
    tbl[1]  = mk(2'b01, 1'b1, BASE + 64'h8,       8'hFF, DEAD,  2'b01, 2'b01, 64'd0, 2'b00);
    tbl[2]  = mk(2'b01, 1'b0, BASE + 64'h8,       8'hFF, 64'd0, 2'b01, 2'b01, DEAD,  2'b00);
    tbl[3]  = mk(2'b01, 1'b1, BASE,               8'hFF, 64'd0, 2'b01, 2'b01, 64'd0, 2'b00);
    tbl[4]  = mk(2'b01, 1'b1, BASE,               8'h0F, ONES,  2'b01, 2'b01, 64'd0, 2'b00);
    tbl[5]  = mk(2'b01, 1'b0, BASE,               8'hFF, 64'd0, 2'b01, 2'b01, HALF,  2'b00);
    tbl[6]  = mk(2'b01, 1'b0, BASE + 64'hC,       8'hFF, 64'd0, 2'b01, 2'b01, DEAD,  2'b00);
    tbl[7]  = mk(2'b01, 1'b1, LAST,               8'hFF, PATT,  2'b01, 2'b01, 64'd0, 2'b00);
    tbl[8]  = mk(2'b01, 1'b1, 64'h7FFF_FFF8,      8'hFF, ONES,  2'b01, 2'b01, 64'd0, 2'b01);
    tbl[9]  = mk(2'b01, 1'b0, 64'h7FFF_FFF8,      8'hFF, 64'd0, 2'b01, 2'b01, 64'd0, 2'b01);
    tbl[10] = mk(2'b01, 1'b1, TOP,                8'hFF, ONES,  2'b01, 2'b01, 64'd0, 2'b01);
    tbl[11] = mk(2'b01, 1'b0, TOP,                8'hFF, 64'd0, 2'b01, 2'b01, 64'd0, 2'b01);
    tbl[12] = mk(2'b01, 1'b0, LAST,               8'hFF, 64'd0, 2'b01, 2'b01, PATT,  2'b00);
    tbl[13] = mk(2'b01, 1'b0, BASE,               8'hFF, 64'd0, 2'b01, 2'b01, HALF,  2'b00);
    tbl[14] = mk(2'b10, 1'b0, BASE + 64'h8,       8'hFF, 64'd0, 2'b10, 2'b10, DEAD,  2'b00);
    tbl[15] = mk(2'b01, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 8'hFF, 64'd0, 2'b01, 2'b01, 64'd0, 2'b01);
    bdat[0] = 64'hA0A0_0000_0000_0001;
    bdat[1] = 64'hB1B1_0000_0000_0002;
    bdat[2] = 64'hC2C2_0000_0000_0003;

    rst_na = 1'b0; rst_nb = 1'b0;
    drive_a(2'b00, 1'b0, BASE, BASE, 8'h00, 64'd0);
    drive_b(2'b00, 1'b0, BASE, BASE, 8'h00, 64'd0);
    cyc(); cyc();
    chk("reset_rvalid_a", {126'd0, rva}, 128'd0);
    chk("reset_rdata_a", rdataa, 128'd0);
    chk("reset_err_b", {126'd0, errb}, 128'd0);
    rst_na = 1'b1; rst_nb = 1'b1;
    cyc();
    chk("idle_gnt_a", {126'd0, gnta}, 128'd0);
    chk("idle_rvalid_b", {126'd0, rvb}, 128'd0);

    // Single-access vectors on the LATENCY=1 instance
    for (int i = 0; i < 16; i++) begin
      drive_a(tbl[i].req, tbl[i].we, tbl[i].addr, tbl[i].addr, tbl[i].be, tbl[i].wd);
      #1;
      chk($sformatf("vec%0d_gnt", i), {126'd0, gnta}, {126'd0, tbl[i].gnt});
      cyc();
      chk($sformatf("vec%0d_rvalid", i), {126'd0, rva}, {126'd0, tbl[i].rv});
      chk($sformatf("vec%0d_rdata", i), rdataa, flat(tbl[i].rv, tbl[i].rd));
      chk($sformatf("vec%0d_err", i), {126'd0, erra}, {126'd0, tbl[i].err});
    end

    // Round-robin with both ports requesting continuously from pointer 0
    drive_a(2'b00, 1'b0, BASE, BASE, 8'h00, 64'd0);
    rst_na = 1'b0;
    cyc();
    rst_na = 1'b1;
    cyc();
    drive_a(2'b11, 1'b0, BASE + 64'h8, BASE, 8'hFF, 64'd0);
    begin
      int n0, n1;
      logic [1:0] eg;
      n0 = 0; n1 = 0;
      for (int i = 0; i < 6; i++) begin
        eg = (i % 2 == 0) ? 2'b01 : 2'b10;
        #1;
        chk($sformatf("rr%0d_gnt", i), {126'd0, gnta}, {126'd0, eg});
        if (i == 5) begin
          cyc();
          drive_a(2'b00, 1'b0, BASE, BASE, 8'h00, 64'd0);
        end else begin
          cyc();
        end
        chk($sformatf("rr%0d_rvalid", i), {126'd0, rva}, {126'd0, eg});
        chk($sformatf("rr%0d_rdata", i), rdataa, flat(eg, (eg == 2'b01) ? DEAD : HALF));
        if (rva[0]) n0++;
        if (rva[1]) n1++;
      end
      cyc();
      chk("rr_tail_rvalid", {126'd0, rva}, 128'd0);
      chk("rr_count_p0", 128'(n0), 128'd3);
      chk("rr_count_p1", 128'(n1), 128'd3);
    end

    // LATENCY=3: fill three words, then back-to-back reads
    for (int k = 0; k < 3; k++) begin
      drive_b(2'b01, 1'b1, BASE + 64'(k * 8), BASE, 8'hFF, bdat[k]);
      cyc();
    end
    drive_b(2'b00, 1'b0, BASE, BASE, 8'h00, 64'd0);
    cyc(); cyc(); cyc(); cyc();
    for (int s = 1; s <= 6; s++) begin
      if (s <= 3) drive_b(2'b01, 1'b0, BASE + 64'((s - 1) * 8), BASE, 8'hFF, 64'd0);
      cyc();
      if (s == 3) drive_b(2'b00, 1'b0, BASE, BASE, 8'h00, 64'd0);
      if (s >= 3 && s <= 5) begin
        chk($sformatf("lat3_s%0d_rvalid", s), {126'd0, rvb}, 128'd1);
        chk($sformatf("lat3_s%0d_rdata", s), rdatab, flat(2'b01, bdat[s-3]));
      end else begin
        chk($sformatf("lat3_s%0d_idle", s), {126'd0, rvb}, 128'd0);
      end
    end

    // Reset one cycle after a grant drops the pending response and the pointer
    drive_b(2'b01, 1'b0, BASE, BASE, 8'hFF, 64'd0);
    #1;
    chk("rst_pre_gnt", {126'd0, gntb}, 128'd1);
    cyc();
    drive_b(2'b00, 1'b0, BASE, BASE, 8'h00, 64'd0);
    rst_nb = 1'b0;
    cyc();
    chk("rst_during_rvalid", {126'd0, rvb}, 128'd0);
    rst_nb = 1'b1;
    for (int s = 3; s <= 7; s++) begin
      cyc();
      chk($sformatf("rst_post_s%0d_rvalid", s), {126'd0, rvb}, 128'd0);
    end
    drive_b(2'b11, 1'b0, BASE, BASE, 8'hFF, 64'd0);
    #1;
    chk("rst_ptr_gnt", {126'd0, gntb}, 128'd1);
    drive_b(2'b00, 1'b0, BASE, BASE, 8'h00, 64'd0);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
